alu_share_ctrl: RTL and testbench

- Sequencer/arbiter that lets two requesters share the single 8-bit `alu` instance: requester 0 is the CPU datapath, requester 1 is an auxiliary unit such as a checksum or DMA engine.
- Arbitrates round-robin and registers operands and SELECT into the ALU.
- Holds them stable for a programmable number of settle cycles, covering the ALU's internal #1/#2 unit delays plus mult/shift depth.
- Captures RESULT/ZERO and returns them to the owning requester with a one-cycle response pulse.

---
 rtl/alu_share_ctrl.sv | 103 ++++++++++
 tb/tb_alu_share_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one 8-bit ALU between two requesters.
// Holds operands for SETTLE_CYCLES edges, then returns RESULT/ZERO.
module alu_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [7:0]  REQ_OP,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  output logic [1:0]  RSP_VALID,
  output logic [7:0]  RSP_RESULT,
  output logic        RSP_ZERO,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [7:0]  ALU_RESULT,
  input  logic        ALU_ZERO,
  output logic        BUSY
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_d;
  logic [3:0] cnt;
  logic       pri;
  logic       owner;
  logic       win;
  logic       grant;
  logic       done;
  logic [3:0] op_w;
  logic [7:0] a_w;
  logic [7:0] b_w;
  logic [7:0] b_eff;

  always_comb begin
    win     = pri;
    state_d = state;
    unique case (REQ_VALID)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = pri;
    endcase
    grant = (state == IDLE) && (|REQ_VALID);
    done  = (state == EXEC) && (cnt == 4'd1);
    REQ_READY = 2'b00;
    if (grant) REQ_READY = win ? 2'b10 : 2'b01;
    op_w = win ? REQ_OP[7:4] : REQ_OP[3:0];
    a_w  = win ? REQ_A[15:8] : REQ_A[7:0];
    b_w  = win ? REQ_B[15:8] : REQ_B[7:0];
    // negate-B only means something for the add code
    b_eff = b_w;
    if (op_w[3] && op_w[2:0] == 3'b001)
      b_eff = ~b_w + 8'd1;
    unique case (state)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    BUSY = (state == EXEC);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt        <= 4'd0;
      pri        <= 1'b0;
      owner      <= 1'b0;
      ALU_DATA1  <= 8'h00;
      ALU_DATA2  <= 8'h00;
      ALU_SELECT <= 3'b000;
      RSP_VALID  <= 2'b00;
      RSP_RESULT <= 8'h00;
      RSP_ZERO   <= 1'b0;
    end else begin
      RSP_VALID <= 2'b00;
      if (grant) begin
        ALU_DATA1  <= a_w;
        ALU_DATA2  <= b_eff;
        ALU_SELECT <= op_w[2:0];
        owner      <= win;
        pri        <= ~win;
        cnt        <= SETTLE;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (done) begin
          RSP_RESULT <= ALU_RESULT;
          RSP_ZERO   <= ALU_ZERO;
          RSP_VALID  <= owner ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: cycle model plus directed vectors,
// with extra SETTLE_CYCLES=1 and =15 instances for latency.
module tb_alu_share_ctrl;

  localparam int S = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  logic [7:0]  REQ_OP;
  logic [15:0] REQ_A;
  logic [15:0] REQ_B;
  logic [1:0]  RSP_VALID;
  logic [7:0]  RSP_RESULT;
  logic        RSP_ZERO;
  logic [7:0]  ALU_DATA1;
  logic [7:0]  ALU_DATA2;
  logic [2:0]  ALU_SELECT;
  logic [7:0]  ALU_RESULT;
  logic        ALU_ZERO;
  logic        BUSY;

  logic [1:0]  x_valid;
  logic [7:0]  x_op;
  logic [15:0] x_a;
  logic [15:0] x_b;
  logic [1:0]  e1_ready, e1_rsp, e15_ready, e15_rsp;
  logic [7:0]  e1_res, e1_d1, e1_d2, e1_ares;
  logic [7:0]  e15_res, e15_d1, e15_d2, e15_ares;
  logic        e1_zero, e1_azero, e1_busy;
  logic        e15_zero, e15_azero, e15_busy;
  logic [2:0]  e1_sel, e15_sel;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  // Reference ALU: 000 forward B, 001 add, 010 and, 011 or
  function automatic logic [8:0] alu_f(input logic [2:0] s,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    logic [7:0] r;
    case (s)
      3'b000:  r = y;
      3'b001:  r = x + y;
      3'b010:  r = x & y;
      3'b011:  r = x | y;
      default: r = 8'h00;
    endcase
    return {r == 8'h00, r};
  endfunction

  assign {ALU_ZERO, ALU_RESULT} = alu_f(ALU_SELECT, ALU_DATA1, ALU_DATA2);
  assign {e1_azero, e1_ares}    = alu_f(e1_sel, e1_d1, e1_d2);
  assign {e15_azero, e15_ares}  = alu_f(e15_sel, e15_d1, e15_d2);

  alu_share_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_RESULT(RSP_RESULT), .RSP_ZERO(RSP_ZERO),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO), .BUSY(BUSY)
  );

  alu_share_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(x_valid), .REQ_READY(e1_ready),
    .REQ_OP(x_op), .REQ_A(x_a), .REQ_B(x_b),
    .RSP_VALID(e1_rsp), .RSP_RESULT(e1_res), .RSP_ZERO(e1_zero),
    .ALU_DATA1(e1_d1), .ALU_DATA2(e1_d2), .ALU_SELECT(e1_sel),
    .ALU_RESULT(e1_ares), .ALU_ZERO(e1_azero), .BUSY(e1_busy)
  );

  alu_share_ctrl #(.SETTLE_CYCLES(15)) dut15 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(x_valid), .REQ_READY(e15_ready),
    .REQ_OP(x_op), .REQ_A(x_a), .REQ_B(x_b),
    .RSP_VALID(e15_rsp), .RSP_RESULT(e15_res), .RSP_ZERO(e15_zero),
    .ALU_DATA1(e15_d1), .ALU_DATA2(e15_d2), .ALU_SELECT(e15_sel),
    .ALU_RESULT(e15_ares), .ALU_ZERO(e15_azero), .BUSY(e15_busy)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  typedef struct {
    logic [1:0] owner;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    logic [7:0] res;
    logic       zero;
  } txn_t;

  // Transaction seen from the requester's side, plain arithmetic
  function automatic txn_t make_txn(input logic w);
    txn_t t;
    logic [3:0] op;
    int a, b, r;
    bit neg;
    op  = w ? REQ_OP[7:4] : REQ_OP[3:0];
    a   = int'(w ? REQ_A[15:8] : REQ_A[7:0]);
    b   = int'(w ? REQ_B[15:8] : REQ_B[7:0]);
    neg = op[3] && op[2:0] == 3'b001;
    case (op[2:0])
      3'b000:  r = b;
      3'b001:  r = neg ? (a - b + 256) % 256 : (a + b) % 256;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      default: r = 0;
    endcase
    t.owner = w ? 2'b10 : 2'b01;
    t.d1    = 8'(a);
    t.d2    = neg ? 8'((256 - b) % 256) : 8'(b);
    t.sel   = op[2:0];
    t.res   = 8'(r);
    t.zero  = (r == 0);
    return t;
  endfunction

  int         ecnt = 0;
  int         hs   = -1;
  logic       m_pri;
  logic [7:0] m_d1, m_d2, m_res;
  logic [2:0] m_sel;
  logic       m_zero;
  txn_t       m_t;

  // Model advanced once per cycle; edge numbers mark issue and capture
  always @(negedge CLK) begin
    logic       busy_e;
    logic [1:0] rsp_e, rdy_e;
    logic       w;
    ecnt++;
    if (!RESET) begin
      hs = -1; m_pri = 1'b0; m_res = 8'h00; m_zero = 1'b0;
      m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'b000;
      check("reset_outs",
            {BUSY, RSP_VALID, RSP_RESULT, RSP_ZERO, REQ_READY},
            {1'b0, 2'b00, 8'h00, 1'b0, 2'b00});
      check("reset_alu", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, 32'h0);
    end else begin
      if (hs >= 0 && ecnt == hs) begin
        m_d1 = m_t.d1; m_d2 = m_t.d2; m_sel = m_t.sel;
      end
      if (hs >= 0 && ecnt == hs + S) begin
        m_res = m_t.res; m_zero = m_t.zero;
      end
      busy_e = (hs >= 0 && ecnt < hs + S);
      rsp_e  = (hs >= 0 && ecnt == hs + S) ? m_t.owner : 2'b00;
      w = (REQ_VALID == 2'b10) ? 1'b1 :
          (REQ_VALID == 2'b01) ? 1'b0 : m_pri;
      rdy_e = (!busy_e && REQ_VALID != 2'b00) ?
              (w ? 2'b10 : 2'b01) : 2'b00;
      check("m_busy", BUSY, busy_e);
      check("m_ready", REQ_READY, rdy_e);
      check("m_rsp_valid", RSP_VALID, rsp_e);
      check("m_rsp_data", {RSP_ZERO, RSP_RESULT}, {m_zero, m_res});
      check("m_alu", {ALU_SELECT, ALU_DATA1, ALU_DATA2},
            {m_sel, m_d1, m_d2});
      if (rdy_e != 2'b00) begin
        hs    = ecnt + 1;
        m_t   = make_txn(w);
        m_pri = ~w;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_req(input int r, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin
      REQ_OP[3:0] = op; REQ_A[7:0] = a; REQ_B[7:0] = b;
    end else begin
      REQ_OP[7:4] = op; REQ_A[15:8] = a; REQ_B[15:8] = b;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (RSP_VALID == 2'b00 && lat < 40) begin
      tick();
      lat++;
    end
    check("rsp_seen", RSP_VALID != 2'b00, 1'b1);
  endtask

  int gq[$];
  int gt[$];

  initial begin
    int lat, l1, l15;
    RESET = 1'b0; REQ_VALID = 2'b00; REQ_OP = 8'h00;
    REQ_A = 16'h0000; REQ_B = 16'h0000;
    x_valid = 2'b00; x_op = 8'h00; x_a = 16'h0000; x_b = 16'h0000;
    tick(); tick();
    RESET = 1'b1;

    // add 5+3 on requester 0
    set_req(0, 4'b0001, 8'h05, 8'h03);
    REQ_VALID = 2'b01;
    #1 check("t1_ready", REQ_READY, 2'b01);
    tick();
    check("t1_ready_exec", REQ_READY, 2'b00);
    check("t1_sel", ALU_SELECT, 3'b001);
    check("t1_d2", ALU_DATA2, 8'h03);
    check("t1_busy0", BUSY, 1'b1);
    REQ_VALID = 2'b00;
    tick();
    check("t1_busy1", BUSY, 1'b1);
    check("t1_norsp", RSP_VALID, 2'b00);
    tick();
    check("t1_rsp", RSP_VALID, 2'b01);
    check("t1_res", RSP_RESULT, 8'h08);
    check("t1_zero", RSP_ZERO, 1'b0);
    check("t1_idle", BUSY, 1'b0);
    tick();
    check("t1_pulse", RSP_VALID, 2'b00);
    check("t1_hold", RSP_RESULT, 8'h08);

    // 7-7 on requester 1, then AND with bit3 set on requester 0
    set_req(1, 4'b1001, 8'h07, 8'h07);
    REQ_VALID = 2'b10;
    tick();
    REQ_VALID = 2'b00;
    check("t2_d2neg", ALU_DATA2, 8'hF9);
    wait_rsp(lat);
    check("t2_lat", lat, 2);
    check("t2_rsp", RSP_VALID, 2'b10);
    check("t2_res", RSP_RESULT, 8'h00);
    check("t2_zero", RSP_ZERO, 1'b1);
    set_req(0, 4'b1010, 8'h3C, 8'h0F);
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    check("t2_and_d2", ALU_DATA2, 8'h0F);
    check("t2_and_sel", ALU_SELECT, 3'b010);
    wait_rsp(lat);
    check("t2_and_res", RSP_RESULT, 8'h0C);
    tick();

    // operands change while in flight
    set_req(0, 4'b0000, 8'h11, 8'h22);
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    set_req(0, 4'b0001, 8'h99, 8'h77);
    tick();
    check("t4_alu", {ALU_SELECT, ALU_DATA1, ALU_DATA2},
          {3'b000, 8'h11, 8'h22});
    wait_rsp(lat);
    check("t4_res", RSP_RESULT, 8'h22);
    tick();

    // reset one cycle into an operation
    set_req(0, 4'b0001, 8'h21, 8'h12);
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    RESET = 1'b0;
    #1;
    check("t5_async", {BUSY, ALU_SELECT, ALU_DATA1, ALU_DATA2},
          {1'b0, 3'b000, 8'h00, 8'h00});
    tick(); tick();
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_norsp", RSP_VALID, 2'b00);
    end

    // both requesters continuously valid
    set_req(0, 4'b0001, 8'h10, 8'h01);
    set_req(1, 4'b0011, 8'hF0, 8'h0F);
    REQ_VALID = 2'b11;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (REQ_READY != 2'b00) begin
        gq.push_back(REQ_READY == 2'b10 ? 1 : 0);
        gt.push_back(t);
      end
      tick();
    end
    REQ_VALID = 2'b00;
    check("t3_ngrants", gq.size(), 4);
    if (gq.size() == 4) begin
      check("t3_order", {gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0]},
            16'h0101);
      check("t3_spacing", {gt[0][7:0], gt[1][7:0], gt[2][7:0], gt[3][7:0]},
            32'h00030609);
    end
    wait_rsp(lat);
    check("t3_last", {RSP_VALID, RSP_RESULT}, {2'b10, 8'hFF});
    tick();

    // latency at the parameter extremes
    x_op = 8'h00; x_a = 16'h0000; x_b = 16'h00A5;
    x_valid = 2'b01;
    #1 check("t6_ready", {e1_ready, e15_ready}, 4'b0101);
    tick();
    l1 = 0; l15 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (l1 == 0 && e1_rsp != 2'b00) begin
        l1 = k;
        check("t6_s1_rsp", {e1_rsp, e1_res, e1_ready},
              {2'b01, 8'hA5, 2'b01});
      end
      if (l15 == 0 && e15_rsp != 2'b00) begin
        l15 = k;
        check("t6_s15_rsp", {e15_rsp, e15_res, e15_ready},
              {2'b01, 8'hA5, 2'b01});
      end
    end
    x_valid = 2'b00;
    check("t6_s1_lat", l1, 1);
    check("t6_s15_lat", l15, 15);
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
